// File: rtl/io_stream_buffer_pkg.sv
// Shared widths and read-FSM encoding for the core I/O stream buffer.
package io_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = $clog2(WORD_BYTES);
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_RESP
  } rd_state_e;

endpackage

// File: rtl/io_stream_buffer_if.sv
// Core I/O port plus UART byte-engine handshake bundle.
// The master side is the core and UART engines; the slave side is the buffer.
interface io_stream_buffer_if;

  logic [io_pkg::BYTE_W-1:0]                    rx_data;
  logic                                         rx_valid;
  logic [io_pkg::BYTE_W-1:0]                    tx_data;
  logic                                         tx_valid;
  logic                                         tx_ready;
  logic                                         input_req;
  logic [io_pkg::BYTE_W*io_pkg::WORD_BYTES-1:0] input_data;
  logic                                         input_valid;
  logic [31:0]                                  output_data;
  logic                                         output_valid;
  logic                                         io_stall;

  modport master (
    output rx_data, rx_valid, tx_ready, input_req, output_data, output_valid,
    input  tx_data, tx_valid, input_data, input_valid, io_stall
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, input_req, output_data, output_valid,
    output tx_data, tx_valid, input_data, input_valid, io_stall
  );

endinterface

// File: rtl/io_stream_buffer_byte_fifo.sv
// Synchronous byte FIFO, 2**AW entries, AW+1-bit pointers with wrap bit.
module io_byte_fifo
  import io_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [BYTE_W-1:0] mem_q [2**AW];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_stream_buffer.sv
// Core I/O stream buffer: packs RX bytes into words, queues TX bytes, stalls the core.
// Optional drop statistics under IO_STREAM_STAT_EN. States: IDLE wait req | COLLECT pop 4 bytes | RESP present word.
module io_stream_buffer
  import io_pkg::*;
#(
  parameter int RX_AW = 8,
  parameter int TX_AW = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
`ifdef IO_STREAM_STAT_EN
  output logic                  rx_overflow,
  output logic [DROP_CNT_W-1:0] rx_drop_cnt,
`endif
  io_stream_buffer_if.slave     bus
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] data_q, data_d;

  logic              rx_full, rx_empty, rx_pop;
  logic [BYTE_W-1:0] rx_byte;
  logic              tx_full, tx_empty;
  logic              unused_hi;

  assign unused_hi = ^bus.output_data[31:BYTE_W];

  io_byte_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (bus.rx_valid),
    .din   (bus.rx_data),
    .pop   (rx_pop),
    .dout  (rx_byte),
    .full  (rx_full),
    .empty (rx_empty)
  );

  io_byte_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (bus.output_valid),
    .din   (bus.output_data[BYTE_W-1:0]),
    .pop   (bus.tx_ready),
    .dout  (bus.tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign rx_pop          = (state_q == ST_COLLECT) & ~rx_empty;
  assign bus.tx_valid    = ~tx_empty;
  assign bus.input_valid = (state_q == ST_RESP);
  assign bus.input_data  = data_q;
  assign bus.io_stall    = (state_q == ST_COLLECT) | (bus.output_valid & tx_full);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.input_req) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (rx_pop) begin
          word_d[{cnt_q, 3'b000} +: BYTE_W] = rx_byte;
          cnt_d = cnt_q + 1'b1;
          // Output word updates only on completion so input_data stays stable between reads.
          if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
            state_d = ST_RESP;
            data_d  = word_d;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef IO_STREAM_STAT_EN
  logic                  rx_drop;
  logic                  ovf_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign rx_drop     = bus.rx_valid & rx_full;
  assign rx_overflow = ovf_q;
  assign rx_drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (rx_drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_io_stream_buffer.sv
// Directed-vector bench for io_stream_buffer; drop statistics checked when IO_STREAM_STAT_EN is defined.
module tb_io_stream_buffer;
  import io_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  io_stream_buffer_if bus ();

`ifdef IO_STREAM_STAT_EN
  logic        rx_overflow;
  logic [15:0] rx_drop_cnt;
`endif

  io_stream_buffer #(.RX_AW(8), .TX_AW(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
`ifdef IO_STREAM_STAT_EN
    .rx_overflow (rx_overflow),
    .rx_drop_cnt (rx_drop_cnt),
`endif
    .bus         (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rx_send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic read_word(output logic [31:0] w);
    int n;
    bus.input_req = 1'b1;
    tick();
    bus.input_req = 1'b0;
    n = 0;
    while (!bus.input_valid && n < 50) begin
      tick();
      n++;
    end
    chk("read_valid_seen", {31'b0, bus.input_valid}, 32'd1);
    w = bus.input_data;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [7:0]  b2 [4];
    int          cnt;

    b2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rstn             = 1'b0;
    bus.rx_data      = '0;
    bus.rx_valid     = 1'b0;
    bus.tx_ready     = 1'b0;
    bus.input_req    = 1'b0;
    bus.output_data  = '0;
    bus.output_valid = 1'b0;
    #2;
    chk("rst_input_data", bus.input_data, 32'h0);
    chk("rst_input_valid", {31'b0, bus.input_valid}, 32'd0);
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    chk("rst_io_stall", {31'b0, bus.io_stall}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // 1: four buffered bytes, fixed latency
    rx_send(8'h78); rx_send(8'h56); rx_send(8'h34); rx_send(8'h12);
    bus.input_req = 1'b1;
    tick();
    bus.input_req = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("t1_stall", {31'b0, bus.io_stall}, 32'd1);
      chk("t1_no_valid", {31'b0, bus.input_valid}, 32'd0);
      tick();
    end
    chk("t1_valid", {31'b0, bus.input_valid}, 32'd1);
    chk("t1_data", bus.input_data, 32'h12345678);
    chk("t1_stall_resp", {31'b0, bus.io_stall}, 32'd0);
    tick();
    chk("t1_valid_pulse", {31'b0, bus.input_valid}, 32'd0);
    chk("t1_data_hold", bus.input_data, 32'h12345678);

    // 2: request on empty RX, bytes trickle in
    bus.input_req = 1'b1;
    tick();
    bus.input_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (9) tick();
      chk("t2_stall_wait", {31'b0, bus.io_stall}, 32'd1);
      chk("t2_no_valid", {31'b0, bus.input_valid}, 32'd0);
      rx_send(b2[k]);
    end
    chk("t2_stall_last", {31'b0, bus.io_stall}, 32'd1);
    tick();
    chk("t2_valid", {31'b0, bus.input_valid}, 32'd1);
    chk("t2_data", bus.input_data, 32'hDEADBEEF);
    chk("t2_stall_resp", {31'b0, bus.io_stall}, 32'd0);
    tick();

    // 3: TX fill, stall on full, order on drain
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      bus.output_valid = 1'b1;
      bus.output_data  = 32'h0000_0041;
      settle();
      if (bus.io_stall) cnt++;
      tick();
    end
    chk("t3_fill_no_stall", cnt, 32'd0);
    bus.output_data = 32'h0000_005A;
    settle();
    chk("t3_full_stall", {31'b0, bus.io_stall}, 32'd1);
    chk("t3_tx_valid", {31'b0, bus.tx_valid}, 32'd1);
    chk("t3_tx_head", {24'b0, bus.tx_data}, 32'h41);
    tick();
    chk("t3_stall_held", {31'b0, bus.io_stall}, 32'd1);
    bus.tx_ready = 1'b1;
    settle();
    chk("t3_stall_ready", {31'b0, bus.io_stall}, 32'd1);
    tick();
    bus.tx_ready = 1'b0;
    settle();
    chk("t3_stall_release", {31'b0, bus.io_stall}, 32'd0);
    tick();
    bus.output_valid = 1'b0;
    bus.tx_ready     = 1'b1;
    for (int i = 0; i < 256; i++) begin
      settle();
      chk("t3_drain_valid", {31'b0, bus.tx_valid}, 32'd1);
      chk("t3_drain_data", {24'b0, bus.tx_data}, (i < 255) ? 32'h41 : 32'h5A);
      tick();
    end
    bus.tx_ready = 1'b0;
    settle();
    chk("t3_empty", {31'b0, bus.tx_valid}, 32'd0);

    // 4: RX overflow by one byte
    for (int i = 0; i < 256; i++) rx_send(8'(i));
`ifdef IO_STREAM_STAT_EN
    chk("t4_ovf_before", {31'b0, rx_overflow}, 32'd0);
`endif
    rx_send(8'hEE);
`ifdef IO_STREAM_STAT_EN
    chk("t4_ovf", {31'b0, rx_overflow}, 32'd1);
    chk("t4_drop_cnt", {16'b0, rx_drop_cnt}, 32'd1);
`endif
    for (int w = 0; w < 64; w++) begin
      read_word(got);
      chk("t4_word", got, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    end

    // 5: reset in the middle of a read
    bus.output_valid = 1'b1;
    bus.output_data  = 32'h0000_0033;
    tick();
    bus.output_valid = 1'b0;
    rx_send(8'h11); rx_send(8'h22);
    bus.input_req = 1'b1;
    tick();
    bus.input_req = 1'b0;
    tick();
    tick();
    chk("t5_stall_mid", {31'b0, bus.io_stall}, 32'd1);
    rstn = 1'b0;
    settle();
    chk("t5_rst_stall", {31'b0, bus.io_stall}, 32'd0);
    chk("t5_rst_valid", {31'b0, bus.input_valid}, 32'd0);
    chk("t5_rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    chk("t5_rst_data", bus.input_data, 32'h0);
`ifdef IO_STREAM_STAT_EN
    chk("t5_rst_ovf", {31'b0, rx_overflow}, 32'd0);
    chk("t5_rst_drop", {16'b0, rx_drop_cnt}, 32'd0);
`endif
    tick();
    rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.input_valid || bus.io_stall) cnt++;
    end
    chk("t5_quiet", cnt, 32'd0);
    rx_send(8'h01); rx_send(8'h02); rx_send(8'h03); rx_send(8'h04);
    read_word(got);
    chk("t5_word", got, 32'h04030201);

    // 6: simultaneous read request and write
    rx_send(8'hA1); rx_send(8'hA2); rx_send(8'hA3); rx_send(8'hA4);
    bus.input_req    = 1'b1;
    bus.output_valid = 1'b1;
    bus.output_data  = 32'hFFFF_FF0A;
    settle();
    chk("t6_no_stall", {31'b0, bus.io_stall}, 32'd0);
    tick();
    bus.input_req    = 1'b0;
    bus.output_valid = 1'b0;
    settle();
    chk("t6_tx_valid", {31'b0, bus.tx_valid}, 32'd1);
    chk("t6_tx_data", {24'b0, bus.tx_data}, 32'h0A);
    chk("t6_stall_c1", {31'b0, bus.io_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stall", {31'b0, bus.io_stall}, 32'd1);
      chk("t6_no_valid", {31'b0, bus.input_valid}, 32'd0);
    end
    tick();
    chk("t6_valid", {31'b0, bus.input_valid}, 32'd1);
    chk("t6_data", bus.input_data, 32'hA4A3A2A1);
    tick();
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    settle();
    chk("t6_tx_drained", {31'b0, bus.tx_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
